// File: rtl/neural_soc_switch_debounce_pkg.sv
// Shared constants and helpers for the neural SoC switch conditioning path.
package neural_soc_pkg;

  localparam int SW_WIDTH        = 8;
  localparam int SW_TICK_DIV     = 50000;
  localparam int SW_STABLE_TICKS = 10;

  // Bits needed to hold values 0..value-1; never returns less than 1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/neural_soc_switch_debounce_if.sv
// Switch bus between the raw board pins and the PIO in_port consumer.
interface neural_soc_switch_debounce_if
  import neural_soc_pkg::*;
#(
  parameter int WIDTH = SW_WIDTH
);

  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_db;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             changed;
  logic             tick;

  modport master (
    output sw_raw,
    input  sw_db,
    input  rise,
    input  fall,
    input  changed,
    input  tick
  );

  modport slave (
    input  sw_raw,
    output sw_db,
    output rise,
    output fall,
    output changed,
    output tick
  );

endinterface

// File: rtl/neural_soc_switch_debounce_bit.sv
// One switch line: two-flop synchroniser, tick-based stability counter,
// debounced output flop and registered rise/fall pulses.
module neural_soc_debounce_bit
  import neural_soc_pkg::*;
#(
  parameter int STABLE_TICKS = SW_STABLE_TICKS
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_raw,
  input  logic i_tick,
  output logic o_db,
  output logic o_rise,
  output logic o_fall
);

  localparam int CNT_W = clog2(STABLE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_db;
  logic             r_rise;
  logic             r_fall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= '0;
      r_db    <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      // Any agreement with the accepted level wipes progress, so a glitch restarts the count.
      if (r_sync2 == r_db) begin
        r_cnt <= '0;
      end else if (i_tick && (r_cnt == CNT_LAST)) begin
        r_db   <= r_sync2;
        r_cnt  <= '0;
        r_rise <= r_sync2;
        r_fall <= ~r_sync2;
      end else if (i_tick) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_db   = r_db;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/neural_soc_switch_debounce.sv
// Switch bus conditioner: shared debounce prescaler plus one debounce slice per line,
// with a combined changed pulse for edge-capture/interrupt logic.
module neural_soc_switch_debounce
  import neural_soc_pkg::*;
#(
  parameter int WIDTH        = SW_WIDTH,
  parameter int TICK_DIV     = SW_TICK_DIV,
  parameter int STABLE_TICKS = SW_STABLE_TICKS
) (
  input  logic                          clk,
  input  logic                          reset_n,
  neural_soc_switch_debounce_if.slave   sw_if
);

  localparam int DIV_W = clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic             w_tick;
  logic [WIDTH-1:0] w_db;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;

  // Free-running; input activity never re-phases it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div <= '0;
    end else if (r_div == DIV_LAST) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  assign w_tick = (r_div == DIV_LAST);

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    neural_soc_debounce_bit #(
      .STABLE_TICKS (STABLE_TICKS)
    ) u_bit (
      .clk     (clk),
      .reset_n (reset_n),
      .i_raw   (sw_if.sw_raw[g]),
      .i_tick  (w_tick),
      .o_db    (w_db[g]),
      .o_rise  (w_rise[g]),
      .o_fall  (w_fall[g])
    );
  end

  assign sw_if.sw_db   = w_db;
  assign sw_if.rise    = w_rise;
  assign sw_if.fall    = w_fall;
  assign sw_if.changed = |(w_rise | w_fall);
  assign sw_if.tick    = w_tick;

endmodule

// File: tb/tb_neural_soc_switch_debounce.sv
// Directed bench for the switch debouncer with TICK_DIV=4, STABLE_TICKS=3.
module tb_neural_soc_switch_debounce;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  neural_soc_switch_debounce_if #(.WIDTH(8)) sw_if ();

  neural_soc_switch_debounce #(
    .WIDTH        (8),
    .TICK_DIV     (4),
    .STABLE_TICKS (3)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sw_if   (sw_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Edges until sw_db==exp (first edge after the drive is 1); 0 if not seen within limit.
  task automatic wait_db(input logic [7:0] exp, input int limit, output int n);
    n = 0;
    for (int c = 1; c <= limit; c++) begin
      @(posedge clk);
      #1;
      if (sw_if.sw_db == exp) begin
        n = c;
        break;
      end
    end
  endtask

  task automatic step(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  int n;
  int ev;
  int r7;
  int ticks;
  int chg;

  initial begin
    total = 0;
    bad   = 0;
    reset_n = 1'b0;
    sw_if.sw_raw = 8'hFF;

    // Reset with all switches high
    step(4);
    chk("rst_db", 32'(sw_if.sw_db), 32'h00);
    chk("rst_rise", 32'(sw_if.rise), 32'h00);
    chk("rst_fall", 32'(sw_if.fall), 32'h00);
    chk("rst_chg", 32'(sw_if.changed), 32'h0);
    chk("rst_tick", 32'(sw_if.tick), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_db(8'hFF, 30, n);
    chk("rst_lat", 32'(n), 32'd12);
    chk("rst_rise_pulse", 32'(sw_if.rise), 32'hFF);
    chk("rst_chg_pulse", 32'(sw_if.changed), 32'h1);
    chk("rst_fall_pulse", 32'(sw_if.fall), 32'h00);
    step(1);
    chk("rst_rise_end", 32'(sw_if.rise), 32'h00);
    chk("rst_chg_end", 32'(sw_if.changed), 32'h0);

    // Prescaler: one tick every 4 cycles
    ticks = 0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk);
      #1;
      if (sw_if.tick) ticks++;
    end
    chk("tick_count", 32'(ticks), 32'd4);

    // Clean step 00 -> 05
    sw_if.sw_raw = 8'h00;
    wait_db(8'h00, 30, n);
    chk("clr_fall", 32'(sw_if.fall), 32'hFF);
    step(3);
    sw_if.sw_raw = 8'h05;
    wait_db(8'h05, 30, n);
    chk("step_lat_ok", 32'((n >= 11) && (n <= 14)), 32'h1);
    chk("step_rise", 32'(sw_if.rise), 32'h05);
    chk("step_fall", 32'(sw_if.fall), 32'h00);
    step(1);
    chk("step_rise_end", 32'(sw_if.rise), 32'h00);

    // Bounce rejection on bit 3
    ev = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (sw_if.rise[3] || sw_if.fall[3] || sw_if.sw_db[3]) ev++;
      if (c % 3 == 0) sw_if.sw_raw[3] = ~sw_if.sw_raw[3];
    end
    sw_if.sw_raw[3] = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (sw_if.rise[3] || sw_if.fall[3] || sw_if.sw_db[3]) ev++;
    end
    chk("bounce_events", 32'(ev), 32'd0);
    chk("bounce_db", 32'(sw_if.sw_db), 32'h05);

    // Bounce then settle high on bit 7
    r7 = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (sw_if.rise[7]) r7++;
      if (c % 3 == 0) sw_if.sw_raw[7] = ~sw_if.sw_raw[7];
    end
    sw_if.sw_raw[7] = 1'b1;
    n = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      #1;
      if (sw_if.rise[7]) r7++;
      if (n == 0 && sw_if.sw_db[7]) n = c;
    end
    chk("settle_lat_ok", 32'((n >= 11) && (n <= 14)), 32'h1);
    chk("settle_rise_cnt", 32'(r7), 32'd1);
    chk("settle_db", 32'(sw_if.sw_db), 32'h85);

    // Simultaneous multi-bit update F0 -> 0F
    sw_if.sw_raw = 8'hF0;
    wait_db(8'hF0, 30, n);
    chk("sim_pre", 32'(sw_if.sw_db), 32'hF0);
    step(2);
    sw_if.sw_raw = 8'h0F;
    n = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      #1;
      if (sw_if.sw_db != 8'hF0) begin
        n = c;
        break;
      end
    end
    chk("sim_db", 32'(sw_if.sw_db), 32'h0F);
    chk("sim_rise", 32'(sw_if.rise), 32'h0F);
    chk("sim_fall", 32'(sw_if.fall), 32'hF0);
    chk("sim_chg", 32'(sw_if.changed), 32'h1);
    chg = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (sw_if.changed) chg++;
    end
    chk("sim_chg_once", 32'(chg), 32'd0);
    chk("sim_lat_ok", 32'((n >= 11) && (n <= 14)), 32'h1);

    // Reset mid-debounce discards the pending count
    sw_if.sw_raw = 8'h00;
    wait_db(8'h00, 30, n);
    step(2);
    sw_if.sw_raw = 8'h01;
    step(6);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_db", 32'(sw_if.sw_db), 32'h00);
    step(3);
    @(negedge clk);
    reset_n = 1'b1;
    wait_db(8'h01, 30, n);
    chk("mid_rst_lat", 32'(n), 32'd12);
    chk("mid_rst_rise", 32'(sw_if.rise), 32'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
